serial_subtractor: RTL

//   Multi-cycle unsigned subtractor: diff = in1 - in2, computed W bits per clock

---
 rtl/serial_subtractor_if.sv | 27 ++
 rtl/serial_subtractor.sv | 105 ++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
//   in_valid/in_ready  : operand handshake, in1 (minuend) and in2 (subtrahend)
//   out_valid/out_ready: result handshake, diff = {borrow, (in1 - in2) mod 2^N}
//   busy               : block is in RUN or DONE
// master drives operands and takes results; slave is the subtractor.
interface serial_subtractor_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   diff;
    logic         busy;

    modport master (
        output in_valid, in1, in2, out_ready,
        input  in_ready, out_valid, diff, busy
    );

    modport slave (
        input  in_valid, in1, in2, out_ready,
        output in_ready, out_valid, diff, busy
    );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor: diff = in1 - in2, W bits per clock from
// the LSB upward with the borrow carried between chunks.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (aborts any operation in flight)
//   bus   : serial_subtractor_if slave modport (operand and result handshakes)
// Parameters: N operand width, W bits per cycle (N % W == 0).
// diff[N] is the final borrow, so diff read as signed N+1 bits is exactly
// in1 - in2. diff and out_valid are registered; in_ready/busy decode state.
module serial_subtractor #(
    parameter int N = 32,
    parameter int W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_subtractor_if.slave    bus
);
    if (N < 1 || W < 1 || W > N || (N % W) != 0) begin : g_param_check
        $error("serial_subtractor: illegal N/W combination");
    end

    localparam int CHUNKS = N / W;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q;
    logic [N-1:0]  a_q, b_q, res_q;
    logic [N-1:0]  a_d, b_d, res_d;
    logic          borrow_q;
    logic [CW-1:0] cnt_q;
    logic [N:0]    diff_q;
    logic          out_valid_q;
    logic [W:0]    step;
    logic [N+W-1:0] res_cat;

    // One chunk of subtraction in W+1 bits; the top bit is the borrow out.
    function automatic logic [W:0] chunk_sub(input logic [W-1:0] x,
                                             input logic [W-1:0] y,
                                             input logic         bin);
        return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
    endfunction

    always_comb begin
        step    = chunk_sub(a_q[W-1:0], b_q[W-1:0], borrow_q);
        // New chunk enters the result from the top; concatenating first keeps
        // the slice legal when W == N.
        res_cat = {step[W-1:0], res_q};
        res_d   = res_cat[N+W-1:W];
        a_d     = a_q >> W;
        b_d     = b_q >> W;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            borrow_q    <= 1'b0;
            cnt_q       <= '0;
            diff_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q      <= bus.in1;
                        b_q      <= bus.in2;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    a_q      <= a_d;
                    b_q      <= b_d;
                    res_q    <= res_d;
                    borrow_q <= step[W];
                    if (cnt_q == LAST) begin
                        diff_q      <= {step[W], res_d};
                        out_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q == RUN) || (state_q == DONE);
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
endmodule
